// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, WAIT_CYCLES stall,
// byte/half/word lanes with sign/zero extension, registered response.
// Ports: clock/reset; req_* request handshake; rsp_* response handshake.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [2**AW];

  logic [AW-1:0] widx;
  logic [31:0]   word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_data;
  logic [31:0]   st_word;
  logic          f3_ok;
  logic          align_ok;
  logic          range_ok;
  logic          acc_err;
  logic          do_access;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

  assign do_access = (state_q == BUSY) && (cnt_q == 4'd0);
  assign widx      = addr_q[AW+1:2];
  assign word      = mem[widx];
  assign range_ok  = ~|addr_q[31:AW+2];
  assign acc_err   = ~(f3_ok && align_ok && range_ok);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Unsigned loads (100/101) exist only for loads.
  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    case (f3_q)
      3'b000: begin
        f3_ok    = 1'b1;
        align_ok = 1'b1;
      end
      3'b001: begin
        f3_ok    = 1'b1;
        align_ok = ~addr_q[0];
      end
      3'b010: begin
        f3_ok    = 1'b1;
        align_ok = (addr_q[1:0] == 2'b00);
      end
      3'b100: begin
        f3_ok    = ~we_q;
        align_ok = 1'b1;
      end
      3'b101: begin
        f3_ok    = ~we_q;
        align_ok = ~addr_q[0];
      end
      default: begin
        f3_ok    = 1'b0;
        align_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    byte_v = word[7:0];
    case (addr_q[1:0])
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = addr_q[1] ? word[31:16] : word[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{byte_v[7] & ~f3_q[2]}}, byte_v};
      2'b01:   ld_data = {{16{half_v[15] & ~f3_q[2]}}, half_v};
      default: ld_data = word;
    endcase
  end

  // Lane merge: unselected lanes keep the current word contents.
  always_comb begin
    st_word = word;
    case (f3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    st_word[7:0]   = wdata_q[7:0];
          2'd1:    st_word[15:8]  = wdata_q[7:0];
          2'd2:    st_word[23:16] = wdata_q[7:0];
          default: st_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) st_word[31:16] = wdata_q[15:0];
        else           st_word[15:0]  = wdata_q[15:0];
      end
      default: st_word = wdata_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_func3;
        cnt_q   <= 4'(WAIT_CYCLES);
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (do_access) begin
        rdata_q <= (acc_err || we_q) ? 32'd0 : ld_data;
        err_q   <= acc_err;
      end
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clock) begin
    if (do_access && we_q && !acc_err) mem[widx] <= st_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus random
// traffic checked against a byte-addressed reference model.
module tb_dmem_responder;

  localparam int AW = 14;
  localparam int WC = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [int unsigned];

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_func3(req_func3),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_op(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] rd, output logic err);
    int unsigned sz;
    logic legal;
    rd = 32'd0;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3[1:0] != 2'd3) && !(f3[2] && (we || f3[1:0] == 2'd2));
    err = !legal || (a % sz != 0) || (a >= (32'd1 << (AW + 2)));
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(sz); i++) mm[a + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < int'(sz); i++)
        rd = rd | (32'(mm.exists(a + i) ? mm[a + i] : 8'h00) << (8 * i));
      if (!f3[2] && sz < 4 && rd[8*sz-1])
        rd = rd | ~((32'd1 << (8 * sz)) - 32'd1);
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic use_lit, input logic [31:0] lit);
    logic [31:0] erd;
    logic eerr;
    int n;
    @(negedge clock);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_we = we;
    req_addr = a;
    req_wdata = wd;
    req_func3 = f3;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    ref_op(we, a, wd, f3, erd, eerr);
    n = 0;
    while (!rsp_valid && n < 64) begin
      @(posedge clock);
      #1 n++;
    end
    chk("latency", 32'(n), 32'(WC + 1));
    chk("rdata", rsp_rdata, use_lit ? lit : erd);
    chk("error", 32'(rsp_error), 32'(eerr));
    if (rsp_ready) begin
      @(posedge clock);
      #1;
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      chk("req_ready_back", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] hold_rd;
    logic hold_err;
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    req_func3 = 3'd0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_error", 32'(rsp_error), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1 chk("post_rst_ready", 32'(req_ready), 32'd1);

    xact(1, 32'h100, 32'hDEADBEEF, 3'b010, 1, 32'h0);
    xact(0, 32'h100, 32'h0, 3'b010, 1, 32'hDEADBEEF);

    xact(1, 32'h101, 32'h55, 3'b000, 1, 32'h0);
    xact(0, 32'h100, 32'h0, 3'b010, 1, 32'hDEAD55EF);
    xact(0, 32'h103, 32'h0, 3'b000, 1, 32'hFFFFFFDE);
    xact(0, 32'h103, 32'h0, 3'b100, 1, 32'h000000DE);

    xact(1, 32'h102, 32'h8001, 3'b001, 1, 32'h0);
    xact(0, 32'h102, 32'h0, 3'b001, 1, 32'hFFFF8001);
    xact(0, 32'h102, 32'h0, 3'b101, 1, 32'h00008001);
    xact(0, 32'h100, 32'h0, 3'b010, 1, 32'h800155EF);

    xact(0, 32'h102, 32'h0, 3'b010, 1, 32'h0);
    xact(1, 32'h101, 32'hFFFF, 3'b001, 1, 32'h0);
    xact(0, 32'h100, 32'h0, 3'b011, 1, 32'h0);
    xact(1, 32'h0004_0000, 32'h1, 3'b010, 1, 32'h0);
    xact(0, 32'h100, 32'h0, 3'b010, 1, 32'h800155EF);

    // Response back-pressure with an ignored request offered meanwhile.
    xact(1, 32'h104, 32'hA5A5A5A5, 3'b010, 0, 32'h0);
    rsp_ready = 1'b0;
    xact(0, 32'h104, 32'h0, 3'b010, 1, 32'hA5A5A5A5);
    hold_rd = rsp_rdata;
    hold_err = rsp_error;
    @(negedge clock);
    req_we = 1'b1;
    req_addr = 32'h104;
    req_wdata = 32'h11111111;
    req_func3 = 3'b010;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, hold_rd);
      chk("hold_error", 32'(rsp_error), 32'(hold_err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clock);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_ready", 32'(req_ready), 32'd1);
    xact(0, 32'h104, 32'h0, 3'b010, 1, 32'hA5A5A5A5);

    // Reset while a store is in BUSY: store must be dropped.
    xact(1, 32'h200, 32'hCAFEF00D, 3'b010, 0, 32'h0);
    @(negedge clock);
    req_we = 1'b1;
    req_addr = 32'h200;
    req_wdata = 32'h12345678;
    req_func3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    chk("busy_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    @(posedge clock);
    @(negedge clock) reset = 1'b0;
    xact(0, 32'h200, 32'h0, 3'b010, 1, 32'hCAFEF00D);

    for (int i = 0; i < 16; i++)
      xact(1, 32'h400 + 32'(4 * i), $urandom, 3'b010, 0, 32'h0);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0001_0000)
                                       : 32'h400 + $urandom_range(0, 63);
      xact(1'($urandom), a, $urandom, 3'($urandom), 0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
